sram_port_arbiter: RTL

- Shares one synchronous single-port SRAM between the CPU instruction-fetch port and the data (load/store) port.
- Both ports use a request / addr_ok / data_ok handshake; the arbiter grants at most one request per cycle, drives the SRAM, and routes the one-cycle-later read data back to the owner.
- It sits between the CPU core (through the MMU's physical addresses) and the unified memory.

---
 rtl/sram_port_arbiter_if.sv | 46 ++++
 rtl/sram_port_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bundle of the fetch port, the data port and the SRAM port around sram_port_arbiter.
// master: the CPU side plus the SRAM model (drives requests and mem_rdata).
// slave:  the arbiter itself (drives handshakes, responses and the SRAM controls).
interface sram_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok;
    logic          inst_data_ok;
    logic [DW-1:0] inst_rdata;

    logic          data_req;
    logic          data_wr;
    logic [3:0]    data_wen;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok;
    logic          data_data_ok;
    logic [DW-1:0] data_rdata;

    logic          mem_en;
    logic [3:0]    mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport master (
        output inst_req, inst_addr,
        output data_req, data_wr, data_wen, data_addr, data_wdata,
        output mem_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_en, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_wen, data_addr, data_wdata,
        input  mem_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_en, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Purpose: shares one synchronous single-port SRAM between the fetch port and the data port.
// Latency: addr_ok combinational in the grant cycle; data_ok registered, exactly one cycle later.
// Backpressure: the tie loser sees addr_ok low and holds its request; data wins ties unless
//   ARB_ROUND_ROBIN_EN is defined, in which case ties go to the port not granted most recently.
module sram_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input logic                clk,
    input logic                rst,
    sram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INST = 2'd1,
        OWN_DATA = 2'd2
    } owner_t;

    owner_t        owner;
    owner_t        owner_nxt;
    logic          grant_inst;
    logic          grant_data;
    logic          store_grant;
    logic          resp_load;     // the access answered this cycle is a load
    logic [AW-1:0] addr_hold;     // last granted address, keeps mem_addr quiet when idle
    logic [DW-1:0] wdata_hold;    // last store data, keeps mem_wdata quiet otherwise
    logic [AW-1:0] mem_addr_c;
    logic [DW-1:0] mem_wdata_c;

`ifdef ARB_ROUND_ROBIN_EN
    localparam logic LG_INST = 1'b0;
    localparam logic LG_DATA = 1'b1;
    logic last_grant;
`endif

    // Pick this cycle's winner and the owner of next cycle's response; nothing wins in reset.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        owner_nxt  = OWN_NONE;
        if (!rst) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (bus.data_req && bus.inst_req) begin
                if (last_grant == LG_INST) begin
                    grant_data = 1'b1;
                end else begin
                    grant_inst = 1'b1;
                end
            end else begin
                grant_data = bus.data_req;
                grant_inst = bus.inst_req;
            end
`else
            // Data belongs to an older instruction, so it must never starve behind fetches.
            grant_data = bus.data_req;
            grant_inst = bus.inst_req && !bus.data_req;
`endif
        end
        if (grant_data) begin
            owner_nxt = OWN_DATA;
        end else if (grant_inst) begin
            owner_nxt = OWN_INST;
        end
    end

    // SRAM address/data mux: the winner drives, otherwise hold the previous values.
    always_comb begin
        store_grant = grant_data && bus.data_wr;
        mem_addr_c  = addr_hold;
        mem_wdata_c = wdata_hold;
        if (grant_data) begin
            mem_addr_c = bus.data_addr;
        end else if (grant_inst) begin
            mem_addr_c = bus.inst_addr;
        end
        if (store_grant) begin
            mem_wdata_c = bus.data_wdata;
        end
    end

    assign bus.inst_addr_ok = grant_inst;
    assign bus.data_addr_ok = grant_data;
    assign bus.mem_en       = grant_inst || grant_data;
    assign bus.mem_wen      = store_grant ? bus.data_wen : 4'b0000;
    assign bus.mem_addr     = mem_addr_c;
    assign bus.mem_wdata    = mem_wdata_c;

    // A response landing in a reset cycle is dropped, so data_ok is also masked by rst.
    assign bus.inst_data_ok = (owner == OWN_INST) && !rst;
    assign bus.data_data_ok = (owner == OWN_DATA) && !rst;
    assign bus.inst_rdata   = bus.inst_data_ok ? bus.mem_rdata : '0;
    assign bus.data_rdata   = (bus.data_data_ok && resp_load) ? bus.mem_rdata : '0;

    // Response-owner state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    // Remember the SRAM drive values and whether the in-flight data access is a load.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_hold  <= '0;
            wdata_hold <= '0;
            resp_load  <= 1'b0;
        end else begin
            addr_hold  <= mem_addr_c;
            wdata_hold <= mem_wdata_c;
            resp_load  <= grant_data && !bus.data_wr;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Track the most recent winner; starts at INST so data takes the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= LG_INST;
        end else if (grant_data) begin
            last_grant <= LG_DATA;
        end else if (grant_inst) begin
            last_grant <= LG_INST;
        end
    end
`endif
endmodule
